// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional madd (op=4) support is enabled by defining MDU_MADD_EN.
module mdu_seq #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        res_wr_q, res_wr_d;

  logic        op_valid, accept, div_signed;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quo, rem;
`ifdef MDU_MADD_EN
  logic [63:0] madd_sum;
`endif

  always_comb begin
`ifdef MDU_MADD_EN
    op_valid = (op <= OP_MADD);
`else
    op_valid = (op <= OP_DIVU);
`endif
    accept = start && !busy_q && op_valid;

    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
`ifdef MDU_MADD_EN
    madd_sum = {hi_q, lo_q} + prod_s;
`endif

    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case.
    div_signed = (op == OP_DIV);
    dvd        = (div_signed && A[31]) ? (~A + 32'd1) : A;
    dvs        = (div_signed && B[31]) ? (~B + 32'd1) : B;
    dvs_safe   = (B == 32'd0) ? 32'd1 : dvs;
    q_mag      = dvd / dvs_safe;
    r_mag      = dvd % dvs_safe;
    quo        = (div_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
    rem        = (div_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    if (accept) begin
      busy_d   = 1'b1;
      res_wr_d = 1'b1;
      case (op)
        OP_MULT:  begin cnt_d = MULT_N; {res_hi_d, res_lo_d} = prod_s; end
        OP_MULTU: begin cnt_d = MULT_N; {res_hi_d, res_lo_d} = prod_u; end
        OP_DIV, OP_DIVU: begin
          cnt_d    = DIV_N;
          res_hi_d = rem;
          res_lo_d = quo;
          res_wr_d = (B != 32'd0);
        end
`ifdef MDU_MADD_EN
        OP_MADD:  begin cnt_d = MULT_N; {res_hi_d, res_lo_d} = madd_sum; end
`endif
        default:  begin cnt_d = MULT_N; end
      endcase
    end else if (busy_q) begin
      if (cnt_q <= 4'd1) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
        if (res_wr_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else begin
      if (mthi) hi_d = A;
      if (mtlo) lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
// Covers madd in both MDU_MADD_EN builds.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0; A = 32'd0; B = 32'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; A = h;
    tick();
    mthi = 1'b0; mtlo = 1'b1; A = l;
    tick();
    mtlo = 1'b0; A = 32'd0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd3;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got 0x%08h expected 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got 0x%08h expected 0", LO); end
  endtask

  task automatic test_mult();
    int cyc;
    start = 1'b1; op = 3'd0; A = 32'hFFFF_FFFD; B = 32'd5;
    tick();
    start = 1'b0;
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mult_hi_early: got 0x%08h expected 0", HI); end
    cyc = 1;
    while (busy && cyc < 40) begin tick(); if (busy) cyc++; end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL mult_cycles: got %0d expected 5", cyc); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got 0x%08h expected 0xffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got 0x%08h expected 0xfffffff1", LO); end
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL multu_cycles: got %0d expected 5", cyc); end
    checks++; if (HI !== 32'h0000_0004) begin errors++; $display("FAIL multu_hi: got 0x%08h expected 0x00000004", HI); end
    checks++; if (LO !== 32'hFFFF_FFF1) begin errors++; $display("FAIL multu_lo: got 0x%08h expected 0xfffffff1", LO); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div_cycles: got %0d expected 10", cyc); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got 0x%08h expected 0xfffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got 0x%08h expected 0xffffffff", HI); end
    run_op(3'd3, 32'd7, 32'd2, cyc);
    checks++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo: got 0x%08h expected 3", LO); end
    checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi: got 0x%08h expected 1", HI); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    cyc = 0;
    repeat (2) begin if (busy) cyc++; tick(); end
    // Mid-flight start and mthi must both be dropped.
    start = 1'b1; op = 3'd0; A = 32'h1234; B = 32'd2; mthi = 1'b1;
    if (busy) cyc++;
    tick();
    start = 1'b0; mthi = 1'b0; A = 32'd0; B = 32'd0;
    check32("ignore_mthi_hi", HI, 32'd1);
    while (busy && cyc < 40) begin cyc++; tick(); end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL ignore_cycles: got %0d expected 10", cyc); end
    check32("ignore_lo", LO, 32'd14);
    check32("ignore_hi", HI, 32'd2);
    repeat (6) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_extend: got %b expected 0", busy); end
    check32("ignore_lo_stable", LO, 32'd14);
  endtask

  task automatic test_div_edge();
    int cyc;
    write_hilo(32'hAA, 32'hBB);
    check32("mthi_hi", HI, 32'hAA);
    check32("mtlo_lo", LO, 32'hBB);
    run_op(3'd2, 32'd1234, 32'd0, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div0_cycles: got %0d expected 10", cyc); end
    check32("div0_hi", HI, 32'hAA);
    check32("div0_lo", LO, 32'hBB);
    run_op(3'd3, 32'd55, 32'd0, cyc);
    check32("divu0_lo", LO, 32'hBB);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check32("div_ovf_lo", LO, 32'h8000_0000);
    check32("div_ovf_hi", HI, 32'd0);
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    mthi = 1'b1; mtlo = 1'b1; A = 32'h55;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check32("both_hi", HI, 32'h55);
    check32("both_lo", LO, 32'h55);
    // Accepted start wins over a same-cycle mtlo.
    start = 1'b1; mtlo = 1'b1; op = 3'd0; A = 32'd2; B = 32'd3;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check32("start_wins_lo_early", LO, 32'h55);
    cyc = 0;
    while (busy && cyc < 40) begin cyc++; tick(); end
    check32("start_wins_lo", LO, 32'd6);
    check32("start_wins_hi", HI, 32'd0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(3'd1, 32'd10, 32'd10, cyc);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_cycles: got %0d expected 5", cyc); end
    check32("b2b_lo", LO, 32'd1);
    check32("b2b_hi", HI, 32'd0);
  endtask

  task automatic test_reserved();
    start = 1'b1; op = 3'd7; A = 32'd9; B = 32'd9;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved_busy: got %b expected 0", busy); end
    check32("reserved_lo", LO, 32'd1);
  endtask

  task automatic test_reset_mid();
    write_hilo(32'h77, 32'h77);
    start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd3;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    check32("rst_mid_hi", HI, 32'd0);
    check32("rst_mid_lo", LO, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        errors++;
        $display("FAIL rst_mid_late_commit: cycle %0d busy=%b HI=0x%08h LO=0x%08h expected 0/0/0", i, busy, HI, LO);
      end
    end
  endtask

  task automatic test_madd();
    int cyc;
    write_hilo(32'd0, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
    checks++; if (cyc !== 5) begin errors++; $display("FAIL madd_cycles: got %0d expected 5", cyc); end
    check32("madd_hi", HI, 32'd1);
    check32("madd_lo", LO, 32'd0);
`else
    checks++; if (cyc !== 0) begin errors++; $display("FAIL madd_reserved_busy: got %0d busy cycles expected 0", cyc); end
    repeat (6) tick();
    check32("madd_reserved_hi", HI, 32'd0);
    check32("madd_reserved_lo", LO, 32'hFFFF_FFFF);
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) tick();
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_div_edge();
    test_mthi_mtlo();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    test_madd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide unit holding HI/LO, driven from the EX stage beside the combinational alu.
- Accepts an operation request (op + operands + start) and holds busy for a fixed latency.
- Commits HI/LO when busy falls; the pipeline stalls HI/LO consumers while busy.
- Also services direct HI/LO writes (mthi/mtlo).

Parameters:
MULT_CYCLES, 5, busy-high cycles for mult/multu (and madd); legal range 1..15
DIV_CYCLES, 10, busy-high cycles for div/divu; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd (macro only), others reserved
A  input  32  operand rs / dividend
B  input  32  operand rt / divisor
mthi  input  1  write HI <= A
mtlo  input  1  write LO <= A
busy  output  1  operation in flight
HI  output  32  HI register (registered output)
LO  output  32  LO register (registered output)

Behaviour:
- Reset (synchronous, reset=1 at an edge): busy=0, HI=0, LO=0, counter=0. Any pending result is discarded; a start in the same cycle is ignored.
- Accept rule: start=1, busy=0, op valid at edge E:
  - Result is computed from A/B sampled at E and held in internal temp regs.
  - Counter loads N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 after E.
- In flight: counter decrements each edge. At edge E+N, HI/LO are written from the temp regs and busy goes to 0.
- busy is high for exactly N cycles. A new start is accepted in the cycle busy reads 0 (back-to-back allowed).
- start while busy=1: ignored entirely; no queuing.
- Reserved op with start: ignored; busy stays 0 and HI/LO are unchanged.
- mthi/mtlo:
  - Take effect at the edge only if busy=0 and no accepted start that cycle (start wins).
  - mthi and mtlo together both apply.
  - Ignored while busy.
- mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
- multu: the same, unsigned.
- div:
  - LO = signed quotient, truncated toward zero.
  - HI = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B=0, div or divu): accepted, busy high for DIV_CYCLES, HI/LO retain their prior values at commit.
- HI/LO hold their values between operations; they are never X after reset.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op=4 (madd) is valid: {HI,LO} <= {HI,LO} + signed(A)*signed(B), wrap mod 2^64.
  - The HI/LO addend is sampled at the accept edge.
  - Latency is MULT_CYCLES.
- Undefined: op=4 is reserved and ignored like ops 5-7.

Test Plan:
- reset, then start op=0 A=0xFFFFFFFD B=5 -> busy=1 for exactly 5 cycles; after fall HI=0xFFFFFFFF, LO=0xFFFFFFF1; multu same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- op=2 A=0xFFFFFFF9 B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; op=3 A=7 B=2 -> LO=3, HI=1.
- During a div, pulse start op=0 and mthi A=0x1234 mid-flight -> both ignored; div result commits unchanged at cycle 10; busy never extends.
- div by zero after HI=0xAA, LO=0xBB (set via mthi/mtlo) -> busy 10 cycles, HI=0xAA, LO=0xBB retained; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult, assert reset at busy cycle 3 -> next edge busy=0, HI=LO=0; no late commit in the following 5 cycles.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd A=1 B=1 -> HI=1, LO=0; without the macro, same stimulus -> busy stays 0, HI/LO unchanged.
